// File: rtl/calc_pkg.sv
// Shared calculator types: ALU op codes, entry FSM states, operand width.
// Imported by the input front end, the ALU and the display controller.
package calc_pkg;

    localparam int OPERAND_W = 4;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        AND = 2'b10,
        OR  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_A,
        S_B,
        S_OP,
        S_GO,
        S_SHOW
    } entry_state_e;

    // One-hot LED view of the entry state; S_GO shows as S_OP.
    function automatic logic [3:0] state_led_of(entry_state_e s);
        logic [3:0] led;
        led = 4'b0001;
        unique case (s)
            S_A:        led = 4'b0001;
            S_B:        led = 4'b0010;
            S_OP, S_GO: led = 4'b0100;
            S_SHOW:     led = 4'b1000;
            default:    led = 4'b0001;
        endcase
        return led;
    endfunction

endpackage

// File: rtl/calc_input_ctrl_if.sv
// Bundle between the board inputs and the calculator core.
// master: drives sw/buttons, reads results; slave: the input controller.
// btn_clear exists only when INPUT_CLEAR_EN is defined.
interface calc_input_ctrl_if;
    import calc_pkg::*;

    logic [OPERAND_W-1:0] sw;
    logic                 btn_enter;
    logic                 btn_mode;
`ifdef INPUT_CLEAR_EN
    logic                 btn_clear;
`endif
    logic [OPERAND_W-1:0] operand1;
    logic [OPERAND_W-1:0] operand2;
    op_e                  op;
    logic                 calc_valid;
    logic                 mode_change;
    logic [3:0]           state_led;

    modport master (
`ifdef INPUT_CLEAR_EN
        output btn_clear,
`endif
        output sw, btn_enter, btn_mode,
        input  operand1, operand2, op,
        input  calc_valid, mode_change, state_led
    );

    modport slave (
`ifdef INPUT_CLEAR_EN
        input  btn_clear,
`endif
        input  sw, btn_enter, btn_mode,
        output operand1, operand2, op,
        output calc_valid, mode_change, state_led
    );

endinterface

// File: rtl/btn_debounce.sv
// Pushbutton path: 2-flop synchroniser, debouncer, registered rising-edge press.
// Ports: clk, reset (sync, active high), raw (async button), press (1-cycle pulse).
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic             level;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            press   <= 1'b0;
            cnt     <= '0;
        end else begin
            s1      <= raw;
            s2      <= s1;
            level_d <= level;
            press   <= level & ~level_d;
            // Any return to the accepted level restarts the stability count.
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/calc_input_ctrl.sv
// Calculator input front end: debounced enter/mode buttons drive the operand
// entry FSM. Ports: clk, reset (sync, active high), bus (calc_input_ctrl_if.slave).
// Define INPUT_CLEAR_EN to add bus.btn_clear, which aborts entry back to S_A.
module calc_input_ctrl
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input logic               clk,
    input logic               reset,
    calc_input_ctrl_if.slave  bus
);

    logic enter_press;
    logic mode_press;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .clk   (clk),
        .reset (reset),
        .raw   (bus.btn_enter),
        .press (enter_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
        .clk   (clk),
        .reset (reset),
        .raw   (bus.btn_mode),
        .press (mode_press)
    );

`ifdef INPUT_CLEAR_EN
    logic clear_press;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clk   (clk),
        .reset (reset),
        .raw   (bus.btn_clear),
        .press (clear_press)
    );
`endif

    entry_state_e         state;
    entry_state_e         nxt;
    logic [OPERAND_W-1:0] op1_nxt;
    logic [OPERAND_W-1:0] op2_nxt;
    op_e                  op_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_A;
            bus.operand1    <= '0;
            bus.operand2    <= '0;
            bus.op          <= ADD;
            bus.calc_valid  <= 1'b0;
            bus.mode_change <= 1'b0;
            bus.state_led   <= 4'b0001;
        end else begin
            state           <= nxt;
            bus.operand1    <= op1_nxt;
            bus.operand2    <= op2_nxt;
            bus.op          <= op_nxt;
            // Outputs follow the next state so they line up with it.
            bus.calc_valid  <= (nxt == S_GO);
            bus.mode_change <= mode_press;
            bus.state_led   <= state_led_of(nxt);
        end
    end

    always_comb begin
        nxt     = state;
        op1_nxt = bus.operand1;
        op2_nxt = bus.operand2;
        op_nxt  = bus.op;
        unique case (state)
            S_A: if (enter_press) begin
                op1_nxt = bus.sw;
                nxt     = S_B;
            end
            S_B: if (enter_press) begin
                op2_nxt = bus.sw;
                nxt     = S_OP;
            end
            S_OP: if (enter_press) begin
                op_nxt = op_e'(bus.sw[1:0]);
                nxt    = S_GO;
            end
            S_GO:   nxt = S_SHOW;
            S_SHOW: if (enter_press) nxt = S_A;
            default: nxt = S_A;
        endcase
`ifdef INPUT_CLEAR_EN
        // Clear overrides whatever enter would have done this cycle.
        if (clear_press) begin
            nxt     = S_A;
            op1_nxt = '0;
            op2_nxt = '0;
            op_nxt  = ADD;
        end
`endif
    end

endmodule

// File: doc/calc_input_ctrl.md
Name: calc_input_ctrl

Overview:
- Input-side front end of the calculator; feeds the seven-segment display controller, which drives seg/an.
- Synchronises and debounces the board pushbuttons, then runs an entry FSM that captures operand1, operand2 and the ALU op from the slide switches.
- Issues a one-cycle calc_valid strobe to the ALU and a one-cycle mode_change pulse to the display controller.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required to accept a button level (10 ms at 100 MHz; benches use 4).
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high reset.
- sw  in  4  slide switches; operand value or op code (sw[1:0]).
- btn_enter  in  1  raw enter pushbutton, asynchronous, bouncy.
- btn_mode  in  1  raw mode pushbutton, asynchronous, bouncy.
- operand1  out  4  latched first operand.
- operand2  out  4  latched second operand.
- op  out  2  latched ALU op (op_e).
- calc_valid  out  1  one-cycle strobe; operands and op are stable while high and until the next capture.
- mode_change  out  1  one-cycle pulse per debounced mode press.
- state_led  out  4  one-hot entry state: bit0 S_A, bit1 S_B, bit2 S_OP, bit3 S_SHOW.

Behaviour:
- Reset: operand1=0, operand2=0, op=ADD, calc_valid=0, mode_change=0, state=S_A, state_led=0001. Synchronisers, debounce counters and debounced levels are cleared to 0.
- Per button path: 2-flop synchroniser, then the debouncer.
  - Debouncer counter clears whenever the synced value equals the debounced level. Otherwise it increments.
  - When the counter is at DEBOUNCE_CYCLES-1 and the synced value still differs, the level takes the synced value and the counter clears.
  - press = level & ~level_d (rising edge only). The falling edge produces no event.
- Latency: with edge 0 the first clock edge sampling raw=1, press is high for exactly one cycle following edge DEBOUNCE_CYCLES+2. The FSM/outputs act on the next edge.
- Glitch rejection: any raw excursion shorter than DEBOUNCE_CYCLES synced cycles produces no press.
- FSM transitions (enter press only; other states ignore it):
  - S_A: operand1<=sw, go to S_B.
  - S_B: operand2<=sw, go to S_OP.
  - S_OP: op<=sw[1:0], go to S_GO.
  - S_GO: lasts one cycle; calc_valid=1, then S_SHOW unconditionally.
  - S_SHOW: enter press goes to S_A. Operands and op hold their old values until overwritten.
- S_GO is reported as S_OP on state_led (S_OP bit held for that cycle).
- mode_change = mode press, registered. It is independent of FSM state and never alters operands or state.
- Simultaneous enter and mode presses are both serviced in the same cycle.
- A button held through reset release produces a press DEBOUNCE_CYCLES+2 edges after the first post-reset edge.
- Reset mid-sequence aborts the entry. Partial captures are discarded (operands return to 0).
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: INPUT_CLEAR_EN.
- Defined:
  - Adds port btn_clear (in, 1) through its own synchroniser and debouncer.
  - A clear press in any state sets operand1=0, operand2=0, op=ADD, state=S_A, and suppresses calc_valid that cycle.
  - Clear has priority over a simultaneous enter press. A simultaneous mode press is still serviced.
- Not defined: no btn_clear port; the only way back to S_A is the S_SHOW enter press or reset.

Decomposition:
- calc_pkg holds:
  - op_e: 2-bit enum ADD=00, SUB=01, AND=10, OR=11.
  - entry_state_e: S_A, S_B, S_OP, S_GO, S_SHOW.
  - OPERAND_W=4, shared with the ALU and display controller.
- One sub-module, btn_debounce: synchroniser, debouncer and rising-edge press pulse, parameterised by DEBOUNCE_CYCLES. Instantiated twice, or three times with INPUT_CLEAR_EN.

Test Plan:
- All benches use DEBOUNCE_CYCLES=4.
- Reset held 3 cycles, buttons low -> all outputs 0, op=00, state_led=0001; no pulses over 50 cycles.
- Full entry: sw=5 enter, sw=3 enter, sw=01 enter (each held 10 cycles) -> operand1=5, operand2=3, op=SUB, calc_valid high exactly one cycle, state_led 0100 then 1000.
- Bounce: btn_enter toggling 3 high / 1 low for 20 cycles, then steady high 10 cycles -> exactly one FSM advance. The press occurs 6 edges after the final rising sample.
- Mode press while in S_B -> one mode_change pulse; state_led stays 0010; operand1 unchanged.
- Reset asserted in S_OP with operand1=5, operand2=3 -> next cycle operands=0, state_led=0001, calc_valid=0.
- INPUT_CLEAR_EN: clear and enter pressed in the same cycle while in S_OP -> state S_A, operands 0, no calc_valid. Mode pressed alongside still yields one mode_change pulse.
